// File: rtl/serial_tx.sv
// Byte-serial 8N1/8N2 transmitter with a 2**FIFO_AW-entry input FIFO and a registered txd.
// Optional parity bit between data and stop bits when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
    parameter int FIFO_AW   = 4,
    parameter int DIV_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DIV_W-1:0]   divisor,
    input  logic               parity_odd,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic               txd_q, txd_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         idx_q, idx_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [7:0]         mem [2**FIFO_AW];
    logic [7:0]         head;
    logic [DIV_W-1:0]   div_eff;
    logic               push, pop, bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic               parity_q, parity_d;
`else
    logic               unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign tx_ready   = (level_q != FULL_LVL);
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr_q];
    assign div_eff    = (divisor < DIV_W'(8)) ? DIV_W'(8) : divisor;
    assign bit_end    = (cnt_q == '0);
    assign txd        = txd_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        txd_d    = txd_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        pop      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (level_q != '0) state_d = S_LOAD;
            end
            S_LOAD: pop = 1'b1;
            S_START: begin
                if (!bit_end) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    cnt_d   = period_q - 1'b1;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (!bit_end) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = period_q - 1'b1;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!bit_end) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    cnt_d   = period_q - 1'b1;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (!bit_end) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (idx_q == 3'(STOP_BITS - 1)) begin
                    // Loading during the last stop clock keeps frames gap-free.
                    if (level_q != '0) pop = 1'b1;
                    else state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = period_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d  = head;
            period_d = div_eff;
            cnt_d    = div_eff - 1'b1;
            txd_d    = 1'b0;
            state_d  = S_START;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = (^head) ^ parity_odd;
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            txd_q    <= 1'b1;
            cnt_q    <= '0;
            period_q <= DIV_W'(8);
            shift_q  <= '0;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            txd_q    <= txd_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
